// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Word-addressed backing store for the memory side of the L2 cache. Accepts
//   single-word read/write requests, waits a fixed LATENCY cycles, and then
//   answers with a one-cycle mem_ready pulse. A read loads mem_rdata on the
//   completing edge; a write commits to the array on that same edge.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   mem_addr     : byte address (offset bits ignored, upper bits alias)
//   mem_wdata    : write data
//   mem_read     : read request level
//   mem_write    : write request level (wins over mem_read)
//   mem_rdata    : registered read data, held until the next completed read
//   mem_ready    : one-cycle completion pulse
//   busy         : high while a request is in flight
//   protocol_err : sticky, set when read and write are accepted together
module main_memory_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  protocol_err
);

  localparam int unsigned OFFSET_W = $clog2(DATA_WIDTH / 8);
  localparam int unsigned INDEX_W  = $clog2(MEM_DEPTH);
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t                  state;
  logic [7:0]              cnt;
  logic [INDEX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    op_write_q;

  // Storage is deliberately not reset so it can map onto a RAM macro.
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [INDEX_W-1:0]      req_index;
  logic                    req;
  logic                    commit_we;
  logic                    addr_unused;

  assign req_index = mem_addr[OFFSET_W +: INDEX_W];
  assign req       = mem_read | mem_write;

  // Offset and upper address bits take no part in decoding.
  assign addr_unused = &{1'b0, mem_addr};

  // Commit on the BUSY->RESP edge only; an abort (request dropped) or an
  // asynchronous reset forces state away from BUSY, so nothing is written.
  assign commit_we = (state == BUSY) && req && (cnt == '0) && op_write_q;

  always_ff @(posedge clk) begin
    if (commit_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      op_write_q   <= 1'b0;
      mem_rdata    <= '0;
      mem_ready    <= 1'b0;
      busy         <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (req) begin
            idx_q      <= req_index;
            wdata_q    <= mem_wdata;
            op_write_q <= mem_write;
            cnt        <= CNT_INIT;
            state      <= BUSY;
            busy       <= 1'b1;
            if (mem_read && mem_write) begin
              protocol_err <= 1'b1;
            end
          end
        end

        BUSY: begin
          if (!req) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            if (!op_write_q) begin
              mem_rdata <= mem[idx_q];
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        RESP: begin
          mem_ready <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 4096;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        protocol_err;

  int errors = 0;
  int checks = 0;

  // Reference model: word store keyed by word index, last read data, sticky error.
  logic [31:0] model_mem [int];
  logic [31:0] model_rdata;
  logic        model_perr;

  main_memory_responder #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_DEPTH (DEPTH),
    .LATENCY   (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Full transaction: request held until mem_ready, which must appear exactly
  // LAT cycles after acceptance and last one cycle.
  task automatic xact(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_addr  = a;
    mem_wdata = d;
    mem_write = wr;
    mem_read  = rd;
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      chk("ready_early", {31'b0, mem_ready}, 32'd0);
      chk("busy_inflight", {31'b0, busy}, 32'd1);
      mem_addr  = $urandom;   // ignored while in flight
      mem_wdata = $urandom;
    end
    @(negedge clk);
    chk("ready_pulse", {31'b0, mem_ready}, 32'd1);
    if (wr) begin
      model_mem[widx(a)] = d;
      if (rd) model_perr = 1'b1;
    end else begin
      model_rdata = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'hx;
    end
    if (model_rdata !== 32'hx) chk("rdata", mem_rdata, model_rdata);
    chk("perr", {31'b0, protocol_err}, {31'b0, model_perr});
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    chk("ready_single", {31'b0, mem_ready}, 32'd0);
    chk("busy_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; mem_addr = '0; mem_wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    model_rdata = 32'h0;
    model_perr  = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_perr", {31'b0, protocol_err}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {mem_rdata[28:0], mem_ready, busy, protocol_err}, 32'd0);
    end

    // Pre-test zero fills
    xact(1'b1, 1'b0, 32'h20, 32'h0);
    xact(1'b1, 1'b0, 32'h40, 32'h0);

    // Write then read
    xact(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    xact(1'b0, 1'b1, 32'h10, 32'h0);
    chk("deadbeef", mem_rdata, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("rdata_hold", mem_rdata, 32'hDEADBEEF);

    // Aliasing and byte offset
    xact(1'b1, 1'b0, 32'h4004, 32'h12345678);
    xact(1'b0, 1'b1, 32'h4, 32'h0);
    chk("alias", mem_rdata, 32'h12345678);
    xact(1'b0, 1'b1, 32'h6, 32'h0);
    chk("offset", mem_rdata, 32'h12345678);

    // Abort: request dropped two cycles after acceptance
    @(negedge clk);
    mem_addr = 32'h20; mem_wdata = 32'hAAAAAAAA; mem_write = 1'b1;
    repeat (2) @(negedge clk);
    mem_write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_noready", {31'b0, mem_ready}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
    end
    chk("abort_rdata", mem_rdata, 32'h12345678);
    xact(1'b0, 1'b1, 32'h20, 32'h0);
    chk("abort_nocommit", mem_rdata, 32'h0);

    // Simultaneous read+write acts as write and sets sticky error
    xact(1'b1, 1'b1, 32'h30, 32'h55550000);
    chk("perr_set", {31'b0, protocol_err}, 32'd1);
    xact(1'b0, 1'b1, 32'h30, 32'h0);
    chk("rw_write", mem_rdata, 32'h55550000);
    // A write to the word just read leaves mem_rdata alone
    xact(1'b1, 1'b0, 32'h30, 32'h0BADF00D);
    chk("write_keeps_rdata", mem_rdata, 32'h55550000);
    chk("perr_sticky", {31'b0, protocol_err}, 32'd1);

    // Async reset mid-BUSY
    @(negedge clk);
    mem_addr = 32'h40; mem_wdata = 32'hCAFEBABE; mem_write = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'b0, mem_ready}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_perr", {31'b0, protocol_err}, 32'd0);
    chk("arst_rdata", mem_rdata, 32'd0);
    mem_write = 1'b0;
    model_perr  = 1'b0;
    model_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 1'b1, 32'h40, 32'h0);
    chk("arst_nocommit", mem_rdata, 32'h0);
    xact(1'b1, 1'b0, 32'h30, 32'h77770000);
    xact(1'b0, 1'b1, 32'h30, 32'h0);
    chk("raw_after_reset", mem_rdata, 32'h77770000);

    // Randomized traffic over a small aliased window
    for (int w = 0; w < 16; w++) xact(1'b1, 1'b0, 32'h100 + 32'(w * 4), $urandom);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3))
          + 32'($urandom_range(0, 7)) * 32'(DEPTH * 4);
      if ($urandom_range(0, 1) == 0) xact(1'b1, 1'b0, a, $urandom);
      else xact(1'b0, 1'b1, a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Word-addressed backing-store responder for the memory side of the L2 cache.
- Accepts single-word read/write requests, models a fixed access latency, and answers with a one-cycle ready pulse.
- Sits below the L2 cache; ports connect directly to the L2 memory interface: L2 mem_data_out -> mem_wdata, mem_rdata -> L2 mem_data_in.
- Used as the system main memory in simulation and as a synthesizable RAM wrapper.

Parameters:
DATA_WIDTH, 32, word width in bits; a multiple of 8.
ADDR_WIDTH, 32, byte-address width.
MEM_DEPTH, 4096, number of words; a power of two.
LATENCY, 4, cycles from request acceptance to mem_ready; legal range 1..255.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
mem_addr  input  ADDR_WIDTH  byte address of the request.
mem_wdata  input  DATA_WIDTH  write data.
mem_read  input  1  read request level.
mem_write  input  1  write request level.
mem_rdata  output  DATA_WIDTH  read data, registered.
mem_ready  output  1  one-cycle completion pulse.
busy  output  1  high while a request is in flight (BUSY or RESP).
protocol_err  output  1  sticky flag: mem_read and mem_write were sampled high together.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, cnt=0.
  - mem_ready=0, mem_rdata=0, busy=0, protocol_err=0.
  - Storage array is not cleared; contents are undefined until written.
  - Reset mid-request discards the request: no commit, no ready.
- Word index: mem_addr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)].
  - Byte-offset bits are ignored.
  - Upper bits are ignored, so addresses alias modulo MEM_DEPTH words.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If mem_read|mem_write is sampled high at edge k:
    - latch the word index, mem_wdata, and op (write if mem_write=1, else read);
    - set cnt=LATENCY-1 and go to BUSY.
  - If both mem_read and mem_write are high at acceptance: op=write and protocol_err is set (it stays set until reset).
- BUSY:
  - If mem_read and mem_write are both sampled low: abort and return to IDLE. No commit, no ready, and mem_rdata is unchanged.
  - Else if cnt==0: go to RESP. On that edge, a write commits the latched data to the array; a read loads mem_rdata from the array.
  - Else decrement cnt.
  - Changes to the request signals during BUSY are ignored; the latched values are used.
- RESP:
  - mem_ready=1 for exactly this one cycle, then unconditionally return to IDLE.
  - mem_ready rises after edge k+LATENCY.
- mem_rdata holds its value until the next completed read. Writes never alter it, including a write to the address last read.
- Requester rule: after seeing mem_ready, the requester deasserts its request the next cycle, or immediately presents a new one.
  - A request still high in IDLE is accepted as a new transaction.
  - Back-to-back throughput is one request per LATENCY+2 cycles.
- busy = (state != IDLE).
- Read-after-write to the same word returns the new data: the commit happens before any later acceptance.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> mem_ready=0, busy=0, mem_rdata=0, protocol_err=0; with no requests, outputs stay unchanged for 20 cycles.
- Write then read, LATENCY=4:
  - write 0xDEADBEEF to 0x0000_0010, accepted at edge k -> mem_ready high for exactly one cycle after edge k+4;
  - then read 0x0000_0010 -> mem_rdata=0xDEADBEEF in the ready cycle, held afterwards.
- Aliasing and offset:
  - write 0x1234_5678 to 0x0000_4004 (MEM_DEPTH=4096) -> read of 0x0000_0004 returns 0x1234_5678;
  - read of 0x0000_0006 returns the same word.
- Abort: write 0xAAAA_AAAA to 0x20, drop mem_write after 2 cycles -> no mem_ready, busy falls, and a later read of 0x20 returns the previous value (0x0 if 0x0 was written earlier).
- Simultaneous read+write of 0x30 with data 0x5555_0000 -> treated as a write and protocol_err=1 (sticky); a later read of 0x30 returns 0x5555_0000.
- Async reset mid-BUSY:
  - assert rst_n low two cycles into a write of 0x40 -> mem_ready and busy drop immediately, nothing commits;
  - after release, a read of 0x40 returns the prior contents (0x0 written pre-test).
